// File: rtl/aes_round_sequencer.sv
// AES-128 encryption round sequencer: walks one block through NR rounds using an
// external SubBytes unit and an external ShiftRows/MixColumns datapath.
module aes_round_sequencer #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         din_valid,
    output logic         din_ready,
    input  logic [127:0] din,
    output logic [3:0]   rk_idx,
    input  logic         rk_valid,
    input  logic [127:0] rk_data,
    output logic [127:0] sb_din,
    input  logic [127:0] sb_dout,
    output logic [127:0] core_din,
    output logic [1:0]   core_sel,
    input  logic [127:0] core_dout,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic [127:0] dout
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ROUND = 2'b01,
        DONE  = 2'b10
    } fsm_t;

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    localparam logic [1:0] SEL_PASS = 2'b00;
    localparam logic [1:0] SEL_FULL = 2'b01;
    localparam logic [1:0] SEL_LAST = 2'b10;

    fsm_t         fsm_q, fsm_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            round_q <= 4'd0;
            state_q <= 128'd0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        fsm_d      = fsm_q;
        round_d    = round_q;
        state_d    = state_q;
        din_ready  = 1'b0;
        dout_valid = 1'b0;
        rk_idx     = 4'd0;
        sb_din     = state_q;
        core_din   = state_q;
        core_sel   = SEL_PASS;

        case (fsm_q)
            IDLE: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    state_d = din;
                    round_d = 4'd0;
                    fsm_d   = ROUND;
                end
            end

            ROUND: begin
                rk_idx = round_q;
                // Round 0 is only the initial AddRoundKey, so SubBytes is bypassed.
                if (round_q != 4'd0) begin
                    core_din = sb_dout;
                    core_sel = (round_q == LAST_ROUND) ? SEL_LAST : SEL_FULL;
                end
                if (rk_valid) begin
                    state_d = core_dout ^ rk_data;
                    if (round_q == LAST_ROUND) begin
                        round_d = 4'd0;
                        fsm_d   = DONE;
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end
            end

            DONE: begin
                dout_valid = 1'b1;
                if (dout_ready) begin
                    fsm_d = IDLE;
                end
            end

            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    assign dout = state_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer: supplies SubBytes, the round datapath and
// round keys from a reference AES model, and checks FIPS-197 ciphertexts and timing.
module tb_aes_round_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         din_valid;
    logic         din_ready;
    logic [127:0] din;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic [127:0] rk_data;
    logic [127:0] sb_din;
    logic [127:0] sb_dout;
    logic [127:0] core_din;
    logic [1:0]   core_sel;
    logic [127:0] core_dout;
    logic         dout_valid;
    logic         dout_ready;
    logic [127:0] dout;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]   sbox   [0:255];
    logic [127:0] rk_tab [0:10];

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

    aes_round_sequencer #(.NR(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din        (din),
        .rk_idx     (rk_idx),
        .rk_valid   (rk_valid),
        .rk_data    (rk_data),
        .sb_din     (sb_din),
        .sb_dout    (sb_dout),
        .core_din   (core_din),
        .core_sel   (core_sel),
        .core_dout  (core_dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout       (dout)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] x);
        logic [127:0] o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = x[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] x);
        logic [127:0] o = '0;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = x[127-32*c -: 8];
            a1 = x[119-32*c -: 8];
            a2 = x[111-32*c -: 8];
            a3 = x[103-32*c -: 8];
            o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    // Reference environment: SubBytes, round datapath and key store.
    always_comb begin
        sb_dout = '0;
        for (int i = 0; i < 16; i++)
            sb_dout[127-8*i -: 8] = sbox[sb_din[127-8*i -: 8]];
    end

    always_comb begin
        case (core_sel)
            2'b01:   core_dout = mix_columns(shift_rows(core_din));
            2'b10:   core_dout = shift_rows(core_din);
            default: core_dout = core_din;
        endcase
    end

    assign rk_data = (rk_idx <= 4'd10) ? rk_tab[rk_idx] : 128'd0;

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
            if (x == 0) inv = 8'h00;
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
                t[31:24] = t[31:24] ^ rc;
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Entered just after a negedge; returns at the negedge where dout_valid first shows.
    task automatic run_block(input logic [127:0] pt, input logic [127:0] key, input bit stall,
                             input logic [127:0] ct, input int lat, input int abort_at);
        int n = 0;
        int step = 0;
        int stalls = 0;
        bit done = 1'b0;
        logic [1:0] es;
        expand_key(key);
        din       = pt;
        din_valid = 1'b1;
        rk_valid  = 1'b1;
        chk("offer_ready", 128'(din_ready), 128'd1);
        @(posedge clk);
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            din_valid = 1'b0;
            if (dout_valid) begin
                done = 1'b1;
            end else if (abort_at >= 0 && int'(rk_idx) == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                chk("abort_din_ready",  128'(din_ready),  128'd1);
                chk("abort_dout_valid", 128'(dout_valid), 128'd0);
                chk("abort_state",      dout,             128'd0);
                chk("abort_rk_idx",     128'(rk_idx),     128'd0);
                return;
            end else if (stall && rk_idx == 4'd5 && stalls < 3) begin
                rk_valid = 1'b0;
                stalls++;
                chk("stall_rk_idx", 128'(rk_idx), 128'd5);
            end else begin
                rk_valid = 1'b1;
                es = (step == 0) ? 2'b00 : (step == 10) ? 2'b10 : 2'b01;
                chk("seq_rk_idx",   128'(rk_idx),   128'(step));
                chk("seq_core_sel", 128'(core_sel), 128'(es));
                step++;
            end
        end
        if (!done) begin
            chk("dout_valid_timeout", 128'd0, 128'd1);
        end else begin
            chk("ciphertext", dout,       ct);
            chk("latency",    128'(n),    128'(lat));
            chk("round_count", 128'(step), 128'd11);
        end
    endtask

    task automatic finish_block(input int bp, input logic [127:0] ct,
                                input bit nv, input logic [127:0] npt);
        for (int i = 0; i < bp; i++) begin
            dout_ready = 1'b0;
            din_valid  = 1'b1;
            din        = ~ct;
            chk("bp_dout_valid", 128'(dout_valid), 128'd1);
            chk("bp_dout",       dout,             ct);
            chk("bp_din_ready",  128'(din_ready),  128'd0);
            chk("done_core_sel", 128'(core_sel),   128'd0);
            chk("done_sb_din",   sb_din,           ct);
            @(negedge clk);
        end
        dout_ready = 1'b1;
        din_valid  = nv;
        din        = npt;
        @(negedge clk);
        dout_ready = 1'b0;
        chk("post_dout_valid", 128'(dout_valid), 128'd0);
        chk("post_din_ready",  128'(din_ready),  128'd1);
        chk("post_rk_idx",     128'(rk_idx),     128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        din_valid  = 1'b0;
        din        = '0;
        rk_valid   = 1'b0;
        dout_ready = 1'b0;
        build_sbox();
        expand_key(KEY_C1);
        repeat (3) @(negedge clk);

        chk("rst_din_ready",  128'(din_ready),  128'd1);
        chk("rst_dout_valid", 128'(dout_valid), 128'd0);
        chk("rst_dout",       dout,             128'd0);
        chk("rst_rk_idx",     128'(rk_idx),     128'd0);
        chk("rst_core_sel",   128'(core_sel),   128'd0);
        chk("rst_sb_din",     sb_din,           128'd0);
        rst = 1'b0;

        // FIPS-197 C.1 with output backpressure.
        run_block(PT_C1, KEY_C1, 1'b0, CT_C1, 12, -1);
        finish_block(4, CT_C1, 1'b0, 128'd0);

        // Key stall at round 5.
        run_block(PT_C1, KEY_C1, 1'b1, CT_C1, 15, -1);
        finish_block(0, CT_C1, 1'b0, 128'd0);

        // Abort at round 7, new block offered as reset releases.
        run_block(PT_C1, KEY_C1, 1'b0, CT_C1, 12, 7);
        rst = 1'b0;
        run_block(PT_B, KEY_B, 1'b0, CT_B, 12, -1);

        // Back-to-back with din_valid held across the handshake.
        finish_block(0, CT_B, 1'b1, PT_C1);
        run_block(PT_C1, KEY_C1, 1'b0, CT_C1, 12, -1);
        finish_block(0, CT_C1, 1'b1, PT_B);
        run_block(PT_B, KEY_B, 1'b0, CT_B, 12, -1);
        finish_block(2, CT_B, 1'b0, 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/aes_round_sequencer.md
AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

Interface
REQ-001 Parameter NR, default 10, number of AES rounds (AES-128); the round counter width SHALL be 4 bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 din_valid  input  1  plaintext block offered.
REQ-005 din_ready  output  1  sequencer can accept a block.
REQ-006 din  input  128  plaintext, byte 0 in [127:120].
REQ-007 rk_idx  output  4  round-key index requested (0..NR).
REQ-008 rk_valid  input  1  rk_data is valid for rk_idx.
REQ-009 rk_data  input  128  round key for rk_idx.
REQ-010 sb_din  output  128  state to the external SubBytes unit.
REQ-011 sb_dout  input  128  SubBytes result, combinational, same cycle.
REQ-012 core_din  output  128  input to the round datapath (ShiftRows/MixColumns).
REQ-013 core_sel  output  2  datapath mode: 00 pass-through, 01 full round, 10 last round (no MixColumns).
REQ-014 core_dout  input  128  datapath result, combinational, same cycle.
REQ-015 dout_valid  output  1  ciphertext available.
REQ-016 dout_ready  input  1  consumer accepts ciphertext.
REQ-017 dout  output  128  ciphertext, equal to the state register.

Function
REQ-018 The FSM SHALL have the states IDLE, ROUND and DONE.
REQ-019 IDLE: din_ready=1; when din_valid=1, capture din into the state register, set round=0 and go to ROUND.
REQ-020 ROUND, round=0: core_din=state, core_sel=00; on rk_valid, state <= core_dout XOR rk_data.
REQ-021 ROUND, 1<=round<=NR-1: sb_din=state, core_din=sb_dout, core_sel=01; on rk_valid, state <= core_dout XOR rk_data.
REQ-022 ROUND, round=NR: as REQ-021 but with core_sel=10; on rk_valid, the state updates and the FSM goes to DONE.
REQ-023 rk_idx SHALL equal round at all times in ROUND, and 0 in IDLE and DONE.
REQ-024 When rk_valid=0 in ROUND, the state and round SHALL hold (stall); there is no timeout.
REQ-025 Each rk_valid=1 cycle in ROUND SHALL increment round by 1; there is no wrap, because round=NR exits to DONE.
REQ-026 DONE: dout_valid=1 and dout=state; on dout_ready=1, go to IDLE and clear dout_valid next cycle.
REQ-027 din_ready SHALL be 0 in ROUND and DONE, so din_valid there is ignored and no block is dropped silently.
REQ-028 Back-to-back blocks: the earliest next acceptance is the cycle after DONE is left; the block has no pipeline overlap.
REQ-029 Latency with rk_valid held at 1: block accepted at cycle T gives dout_valid=1 at T+NR+2 (12 cycles for NR=10).
REQ-030 dout SHALL hold stable while dout_valid=1 and dout_ready=0.
REQ-031 core_sel SHALL be 00 and sb_din/core_din SHALL equal state in IDLE and DONE.
REQ-032 All datapath operations are bitwise over 128 bits; there are no carries and no truncation.

Reset
REQ-033 While rst=1: FSM=IDLE, round=0, state=0, so din_ready=1, dout_valid=0, dout=0, rk_idx=0, core_sel=00.
REQ-034 rst asserted mid-ROUND or in DONE SHALL abort the block at the next edge with no ciphertext output; rst has priority over all other inputs.
REQ-035 A block offered in the cycle rst deasserts SHALL be accepted normally, since din_ready=1 after reset.

Verification
REQ-036 FIPS-197 C.1: key 000102..0f (round keys supplied), pt 00112233445566778899aabbccddeeff -> dout 69c4e0d8 6a7b0430 d8cdb780 70b4c55a at T+12.
REQ-037 Stall: drop rk_valid for 3 cycles at round 5 -> rk_idx holds at 5, the same ciphertext appears, latency is 15.
REQ-038 Output backpressure: dout_ready=0 for 4 cycles -> dout_valid stays 1, dout is stable, din_ready=0 and din_valid is ignored.
REQ-039 Reset mid-round: rst=1 at round 7 -> next cycle din_ready=1, dout_valid=0, state=0; a new block then completes correctly.
REQ-040 Back-to-back: two FIPS vectors with din_valid held -> second accepted the cycle after the first handshake; both outputs correct.
REQ-041 Sequence check: in every round, core_sel matches 00 / 01x9 / 10 and rk_idx steps 0..10 exactly once each.
